// File: rtl/v2f_seq_wide_mul.sv
// Sequential WIDTH x WIDTH multiplier issuing one LIMB x LIMB partial product per cycle.
// Every multi-word add or negate ripples a carry through LIMB-wide slices, so no single adder exceeds 2*LIMB bits.
module v2f_seq_wide_mul #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned LIMB   = 16,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned FULL   = 1
) (
    input  logic                                     pos_clk,
    input  logic                                     pos_arst,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [WIDTH-1:0]                         a,
    input  logic [WIDTH-1:0]                         b,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output logic [(FULL != 0 ? 2*WIDTH : WIDTH)-1:0] y,
    output logic                                     busy
);
    localparam int unsigned N  = WIDTH / LIMB;
    localparam int unsigned RW = (FULL != 0) ? 2 * WIDTH : WIDTH;
    localparam int unsigned RN = RW / LIMB;
    localparam int unsigned CW = $clog2(N);
    localparam int unsigned PW = 2 * LIMB;
    localparam int unsigned SW = LIMB + 1;

    typedef enum logic [1:0] {IDLE, MUL, SIGN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             neg_q;
    logic [RW-1:0]    acc;
    logic [CW-1:0]    i_q;
    logic [CW-1:0]    j_q;

    logic [LIMB-1:0]  a_limb;
    logic [LIMB-1:0]  b_limb;
    logic [PW-1:0]    pp;
    logic [RW-1:0]    acc_sum;
    logic [RW-1:0]    acc_neg;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             j_last;
    logic             pair_last;
    int               pos;

    // Two's complement negate: invert, then add one with a carry rippled limb by limb.
    function automatic logic [RW-1:0] negate(input logic [RW-1:0] x);
        logic [RW-1:0]   r;
        logic [LIMB-1:0] inv;
        logic [SW-1:0]   s;
        logic            c;
        r = '0;
        c = 1'b1;
        for (int k = 0; k < int'(RN); k++) begin
            inv = ~x[k*LIMB +: LIMB];
            s   = SW'(inv) + SW'(c);
            r[k*LIMB +: LIMB] = s[LIMB-1:0];
            c   = s[SW-1];
        end
        return r;
    endfunction

    // Operand magnitudes; the most negative value maps onto its unsigned magnitude.
    always_comb begin
        a_abs = a;
        b_abs = b;
        if (SIGNED != 0) begin
            if (a[WIDTH-1]) a_abs = WIDTH'(negate(RW'(a)));
            if (b[WIDTH-1]) b_abs = WIDTH'(negate(RW'(b)));
        end
    end

    // Current limb pair, its product and the position of the last pair.
    always_comb begin
        a_limb = '0;
        b_limb = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (k == int'(i_q)) a_limb = a_q[k*LIMB +: LIMB];
            if (k == int'(j_q)) b_limb = b_q[k*LIMB +: LIMB];
        end
        pp        = PW'(a_limb) * PW'(b_limb);
        pos       = int'(i_q) + int'(j_q);
        j_last    = (FULL != 0) ? (int'(j_q) == int'(N) - 1) : (pos == int'(N) - 1);
        pair_last = j_last && (int'(i_q) == int'(N) - 1);
    end

    // Accumulate the shifted product; the high half falls off the top when truncating.
    always_comb begin
        logic            carry;
        logic [LIMB-1:0] addend;
        logic [LIMB-1:0] acc_limb;
        logic [SW-1:0]   s;
        carry   = 1'b0;
        acc_sum = '0;
        for (int k = 0; k < int'(RN); k++) begin
            addend = '0;
            if (k == pos)          addend = pp[LIMB-1:0];
            else if (k == pos + 1) addend = pp[PW-1:LIMB];
            acc_limb = acc[k*LIMB +: LIMB];
            s        = SW'(acc_limb) + SW'(addend) + SW'(carry);
            acc_sum[k*LIMB +: LIMB] = s[LIMB-1:0];
            carry    = s[SW-1];
        end
    end

    always_comb acc_neg = negate(acc);

    always_ff @(posedge pos_clk or posedge pos_arst) begin
        if (pos_arst) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            neg_q     <= 1'b0;
            acc       <= '0;
            i_q       <= '0;
            j_q       <= '0;
            y         <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        a_q      <= a_abs;
                        b_q      <= b_abs;
                        neg_q    <= (SIGNED != 0) ? (a[WIDTH-1] ^ b[WIDTH-1]) : 1'b0;
                        acc      <= '0;
                        i_q      <= '0;
                        j_q      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc_sum;
                    if (j_last) begin
                        j_q <= '0;
                        i_q <= i_q + CW'(1);
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                    if (pair_last) begin
                        if (SIGNED != 0) begin
                            state <= SIGN;
                        end else begin
                            y         <= acc_sum;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                            state     <= DONE;
                        end
                    end
                end
                SIGN: begin
                    y         <= neg_q ? acc_neg : acc;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_v2f_seq_wide_mul.sv
// Bench for v2f_seq_wide_mul: four configurations checked against directed vectors and an arithmetic model.
module tb_v2f_seq_wide_mul;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  in_valid;
    logic [3:0]  out_ready;
    wire  [3:0]  in_ready;
    wire  [3:0]  out_valid;
    wire  [3:0]  busy;
    logic [63:0] a [4];
    logic [63:0] b [4];
    wire [127:0] y_fu;
    wire [127:0] y_fs;
    wire [63:0]  y_tu;
    wire [63:0]  y_w;
    int          total = 0;
    int          bad = 0;
    int          cyc;
    bit          seen;

    typedef struct {
        int          d;
        logic [63:0] a;
        logic [63:0] b;
        logic [127:0] y;
    } vec_t;
    vec_t tbl [11];

    always #5 clk = ~clk;

    // d=0: 64 full unsigned, d=1: 64 truncated unsigned, d=2: 64 full signed, d=3: 32 full unsigned
    v2f_seq_wide_mul #(.WIDTH(64), .LIMB(16), .SIGNED(0), .FULL(1)) u_fu (
        .pos_clk(clk), .pos_arst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a[0]), .b(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .y(y_fu), .busy(busy[0]));
    v2f_seq_wide_mul #(.WIDTH(64), .LIMB(16), .SIGNED(0), .FULL(0)) u_tu (
        .pos_clk(clk), .pos_arst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a[1]), .b(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .y(y_tu), .busy(busy[1]));
    v2f_seq_wide_mul #(.WIDTH(64), .LIMB(16), .SIGNED(1), .FULL(1)) u_fs (
        .pos_clk(clk), .pos_arst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a[2]), .b(b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .y(y_fs), .busy(busy[2]));
    v2f_seq_wide_mul #(.WIDTH(32), .LIMB(16), .SIGNED(0), .FULL(1)) u_w (
        .pos_clk(clk), .pos_arst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .a(a[3][31:0]), .b(b[3][31:0]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
        .y(y_w), .busy(busy[3]));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] get_y(input int d);
        case (d)
            0:       return y_fu;
            1:       return {64'b0, y_tu};
            2:       return y_fs;
            default: return {64'b0, y_w};
        endcase
    endfunction

    function automatic int lat_of(input int d);
        case (d)
            0:       return 16;
            1:       return 10;
            2:       return 17;
            default: return 4;
        endcase
    endfunction

    // Exact product of the operands, reduced to what each configuration returns.
    function automatic logic [127:0] model(input int d, input logic [63:0] x, input logic [63:0] z);
        logic signed [127:0] sx;
        logic signed [127:0] sz;
        logic [63:0]         lo;
        case (d)
            0: return {64'b0, x} * {64'b0, z};
            1: begin
                lo = x * z;
                return {64'b0, lo};
            end
            2: begin
                sx = {{64{x[63]}}, x};
                sz = {{64{z[63]}}, z};
                return sx * sz;
            end
            default: return {64'b0, x[31:0]} * {64'b0, z[31:0]};
        endcase
    endfunction

    task automatic do_op(input int d, input logic [63:0] av, input logic [63:0] bv,
                         input logic [127:0] ey, input string nm);
        int n;
        n = 0;
        out_ready[d] = 1'b1;
        while (!in_ready[d] && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_rdy"}, 128'(in_ready[d]), 128'd1);
        a[d] = av;
        b[d] = bv;
        in_valid[d] = 1'b1;
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        chk({nm, "_busy"}, 128'(busy[d]), 128'd1);
        n = 0;
        while (!out_valid[d] && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, 128'(n), 128'(lat_of(d)));
        chk({nm, "_y"}, get_y(d), ey);
        @(posedge clk); #1;
        chk({nm, "_drop"}, 128'(out_valid[d]), 128'd0);
    endtask

    // Random traffic with valid/ready gaps on the 32-bit instance, scoreboarded in order.
    task automatic random_stream();
        logic [63:0] q [$];
        logic [63:0] av;
        logic [63:0] bv;
        logic [63:0] yv;
        logic [63:0] ev;
        int          sent;
        int          got;
        int          n;
        bit          hs_in;
        bit          hs_out;
        sent = 0;
        got  = 0;
        n    = 0;
        in_valid[3] = 1'b0;
        while (got < 1000 && n < 60000) begin
            if (!in_valid[3] && sent < 1000 && $urandom_range(0, 3) != 0) begin
                a[3] = {32'b0, $urandom()};
                b[3] = {32'b0, $urandom()};
                in_valid[3] = 1'b1;
            end
            out_ready[3] = ($urandom_range(0, 2) != 0);
            hs_in  = in_valid[3] && in_ready[3];
            hs_out = out_valid[3] && out_ready[3];
            yv = y_w;
            av = a[3];
            bv = b[3];
            @(posedge clk); #1;
            n++;
            if (hs_in) begin
                ev = 64'(model(3, av, bv));
                q.push_back(ev);
                sent++;
                in_valid[3] = 1'b0;
            end
            if (hs_out) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rs_extra actual=%h required=no_result", yv);
                end else begin
                    ev = q.pop_front();
                    chk($sformatf("rs_y%0d", got), 128'(yv), 128'(ev));
                end
                got++;
            end
        end
        chk("rs_sent", 128'(sent), 128'd1000);
        chk("rs_got", 128'(got), 128'd1000);
        chk("rs_left", 128'(q.size()), 128'd0);
    endtask

    initial begin
        tbl[0]  = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
        tbl[1]  = '{1, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 128'h0000_0002_0000_0001};
        tbl[2]  = '{2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF1};
        tbl[3]  = '{2, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 128'h0000_0000_0000_0000_8000_0000_0000_0000};
        tbl[4]  = '{0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0};
        tbl[5]  = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 128'd1};
        tbl[6]  = '{2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 128'h4000_0000_0000_0000_0000_0000_0000_0000};
        tbl[7]  = '{2, 64'd7, 64'hFFFF_FFFF_FFFF_FFFA, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6};
        tbl[8]  = '{3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'hFFFF_FFFE_0000_0001};
        tbl[9]  = '{3, 64'h1234_5678, 64'h10, 128'h1_2345_6780};
        tbl[10] = '{0, 64'd7, 64'd6, 128'd42};

        rst       = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int k = 0; k < 4; k++) begin
            a[k] = '0;
            b[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("rst_rdy%0d", d), 128'(in_ready[d]), 128'd0);
            chk($sformatf("rst_ov%0d", d), 128'(out_valid[d]), 128'd0);
            chk($sformatf("rst_busy%0d", d), 128'(busy[d]), 128'd0);
            chk($sformatf("rst_y%0d", d), get_y(d), 128'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 4; d++)
            chk($sformatf("rel_rdy%0d", d), 128'(in_ready[d]), 128'd1);

        for (int t = 0; t < 11; t++)
            do_op(tbl[t].d, tbl[t].a, tbl[t].b, tbl[t].y, $sformatf("vec%0d", t));

        // Backpressure: result held, new request ignored until the consumer takes it.
        out_ready[0] = 1'b0;
        a[0] = 64'd3;
        b[0] = 64'd4;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        cyc = 0;
        while (!out_valid[0] && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("bp_lat", 128'(cyc), 128'd16);
        chk("bp_y", y_fu, 128'd12);
        a[0] = 64'd9;
        b[0] = 64'd9;
        in_valid[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_ov%0d", k), 128'(out_valid[0]), 128'd1);
            chk($sformatf("bp_y%0d", k), y_fu, 128'd12);
            chk($sformatf("bp_rdy%0d", k), 128'(in_ready[0]), 128'd0);
        end
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_rel_ov", 128'(out_valid[0]), 128'd0);
        chk("bp_rel_rdy", 128'(in_ready[0]), 128'd1);
        chk("bp_rel_busy", 128'(busy[0]), 128'd0);
        do_op(0, 64'd5, 64'd5, 128'd25, "bp_next");

        // Asynchronous reset in the middle of a multiply discards it.
        a[0] = 64'd123456789;
        b[0] = 64'd987654321;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("arst_acc_busy", 128'(busy[0]), 128'd1);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        chk("arst_busy", 128'(busy[0]), 128'd0);
        chk("arst_rdy", 128'(in_ready[0]), 128'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid[0]) seen = 1'b1;
        end
        chk("arst_no_ov", 128'(seen), 128'd0);
        chk("arst_y", y_fu, 128'd0);
        do_op(0, 64'd7, 64'd6, 128'd42, "arst_next");

        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 20; n++) begin
                logic [63:0] av;
                logic [63:0] bv;
                av = {$urandom(), $urandom()};
                bv = {$urandom(), $urandom()};
                do_op(d, av, bv, model(d, av, bv), $sformatf("rnd%0d_%0d", d, n));
            end
        end

        random_stream();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
